// File: rtl/high_page_controller.sv
// High-page (FE00-FFFF) address decoder with bus-address hold and OAM DMA engine.
module high_page_controller #(
   parameter int unsigned N_IO_CH   = 8,
   parameter logic [7:0]  DMA_REG   = 8'h46,
   parameter int unsigned DMA_LEN   = 160,
   parameter int unsigned DMA_DELAY = 1
) (
   input  logic                 i_Clk,
   input  logic                 i_nRst,
   input  logic                 i_Enable,
   input  logic [15:0]          i_Address,
   input  logic                 i_Address_Out,
   input  logic                 i_data_access,
   input  logic                 i_Write,
   input  logic [7:0]           i_Wdata,
   output logic                 o_Miss,
   output logic                 o_Oam_Enable,
   output logic [7:0]           o_Oam_Address,
   output logic                 o_Unusable,
   output logic [N_IO_CH-1:0]   o_Io_Enable,
   output logic [3:0]           o_Io_Address,
   output logic                 o_High_Ram_Enable,
   output logic [6:0]           o_High_Ram_Address,
   output logic                 o_Ie_Enable,
   output logic [7:0]           o_Dma_Reg,
   output logic                 o_Dma_Reg_Enable,
   output logic                 o_Dma_Active,
   output logic                 o_Dma_Read,
   output logic [15:0]          o_Dma_Src_Address,
   input  logic [7:0]           i_Dma_Data,
   output logic                 o_Dma_Oam_Write,
   output logic [7:0]           o_Dma_Oam_Address,
   output logic [7:0]           o_Dma_Oam_Data
);

   localparam int unsigned     DLY_W    = 16;
   localparam logic [7:0]       LAST_IDX = 8'(DMA_LEN - 1);
   localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(DMA_DELAY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_XFER
   } dma_state_t;

   dma_state_t       state;
   logic [15:0]      held_address;
   logic [15:0]      active_address;
   logic [7:0]       src_page;
   logic [7:0]       index;
   logic [DLY_W-1:0] delay_count;

   logic top_hit;
   logic oam_space;
   logic oam_range;
   logic io_space;
   logic hram_hit;
   logic ie_hit;
   logic dma_reg_hit;
   logic trigger;

   // Bus address currently being decoded: live when driven, otherwise the last one seen.
   assign active_address = i_Address_Out ? i_Address : held_address;

   // Region classification of the active address.
   always_comb begin
      top_hit     = (active_address[15:9] == 7'h7F);
      oam_space   = top_hit & ~active_address[8];
      oam_range   = oam_space & (active_address[7:0] < 8'hA0);
      io_space    = top_hit & active_address[8] & ~active_address[7];
      hram_hit    = top_hit & active_address[8] & active_address[7] & (active_address[6:0] != 7'h7F);
      ie_hit      = (active_address == 16'hFFFF);
      dma_reg_hit = (active_address == {8'hFF, DMA_REG});
   end

   // Access-gated selects; OAM is fenced off from the CPU while DMA owns it.
   always_comb begin
      o_Miss             = i_data_access & ~top_hit;
      o_Oam_Enable       = i_data_access & oam_range & ~o_Dma_Active;
      o_Unusable         = i_data_access & oam_space & (~oam_range | o_Dma_Active);
      o_High_Ram_Enable  = i_data_access & hram_hit;
      o_Ie_Enable        = i_data_access & ie_hit;
      o_Dma_Reg_Enable   = i_data_access & dma_reg_hit;
      o_Oam_Address      = active_address[7:0];
      o_Io_Address       = active_address[3:0];
      o_High_Ram_Address = active_address[6:0];
      o_Io_Enable        = '0;
      for (int c = 0; c < int'(N_IO_CH); c++) begin
         o_Io_Enable[c] = i_data_access & io_space & ~dma_reg_hit &
                          (active_address[6:4] == 3'(c));
      end
   end

   assign trigger = i_Enable & i_data_access & i_Write & o_Dma_Reg_Enable;

   // DMA status and copy-port outputs follow the registered state directly.
   always_comb begin
      o_Dma_Active      = (state != S_IDLE);
      o_Dma_Read        = (state == S_XFER);
      o_Dma_Oam_Write   = o_Dma_Read;
      o_Dma_Src_Address = {src_page, index};
      o_Dma_Oam_Address = index;
      o_Dma_Oam_Data    = o_Dma_Read ? i_Dma_Data : 8'h00;
   end

   // Latch the bus address whenever the CPU drives one on a tick.
   always_ff @(posedge i_Clk or negedge i_nRst) begin
      if (!i_nRst) begin
         held_address <= 16'h0000;
      end else if (i_Enable && i_Address_Out) begin
         held_address <= i_Address;
      end
   end

   // DMA sequencer; a register write always restarts, even over the final copy.
   always_ff @(posedge i_Clk or negedge i_nRst) begin
      if (!i_nRst) begin
         state       <= S_IDLE;
         o_Dma_Reg   <= 8'h00;
         src_page    <= 8'h00;
         index       <= 8'h00;
         delay_count <= '0;
      end else if (i_Enable) begin
         if (trigger) begin
            o_Dma_Reg   <= i_Wdata;
            src_page    <= (i_Wdata >= 8'hE0) ? 8'(i_Wdata - 8'h20) : i_Wdata;
            index       <= 8'h00;
            delay_count <= DLY_INIT;
            state       <= S_DELAY;
         end else begin
            case (state)
               S_DELAY: begin
                  delay_count <= DLY_W'(delay_count - 1'b1);
                  if (delay_count <= DLY_W'(1)) begin
                     state <= S_XFER;
                  end
               end
               S_XFER: begin
                  index <= 8'(index + 8'd1);
                  if (index == LAST_IDX) begin
                     state <= S_IDLE;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_high_page_controller.sv
// Scoreboard bench for high_page_controller: decode vectors and DMA copy stream.
module tb_high_page_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        addr_out = 1'b0;
   logic        acc = 1'b0;
   logic        wr = 1'b0;
   logic [7:0]  wdata = 8'h00;

   logic        o_Miss, o_Oam_Enable, o_Unusable, o_High_Ram_Enable, o_Ie_Enable;
   logic [7:0]  o_Oam_Address, o_Io_Enable, o_Dma_Reg;
   logic [3:0]  o_Io_Address;
   logic [6:0]  o_High_Ram_Address;
   logic        o_Dma_Reg_Enable, o_Dma_Active, o_Dma_Read, o_Dma_Oam_Write;
   logic [15:0] o_Dma_Src_Address;
   logic [7:0]  o_Dma_Oam_Address, o_Dma_Oam_Data;
   logic [7:0]  dma_data;

   int checks = 0;
   int errors = 0;

   logic [33:0] dq[$];
   string       dname[$];
   logic        chk_req = 1'b0;
   logic [31:0] wq[$];
   logic [33:0] mon_e;
   logic [31:0] mon_w;
   string       mon_n;

   high_page_controller dut (
      .i_Clk              (clk),
      .i_nRst             (rst_n),
      .i_Enable           (en),
      .i_Address          (addr),
      .i_Address_Out      (addr_out),
      .i_data_access      (acc),
      .i_Write            (wr),
      .i_Wdata            (wdata),
      .o_Miss             (o_Miss),
      .o_Oam_Enable       (o_Oam_Enable),
      .o_Oam_Address      (o_Oam_Address),
      .o_Unusable         (o_Unusable),
      .o_Io_Enable        (o_Io_Enable),
      .o_Io_Address       (o_Io_Address),
      .o_High_Ram_Enable  (o_High_Ram_Enable),
      .o_High_Ram_Address (o_High_Ram_Address),
      .o_Ie_Enable        (o_Ie_Enable),
      .o_Dma_Reg          (o_Dma_Reg),
      .o_Dma_Reg_Enable   (o_Dma_Reg_Enable),
      .o_Dma_Active       (o_Dma_Active),
      .o_Dma_Read         (o_Dma_Read),
      .o_Dma_Src_Address  (o_Dma_Src_Address),
      .i_Dma_Data         (dma_data),
      .o_Dma_Oam_Write    (o_Dma_Oam_Write),
      .o_Dma_Oam_Address  (o_Dma_Oam_Address),
      .o_Dma_Oam_Data     (o_Dma_Oam_Data)
   );

   always #5 clk = ~clk;

   // Source memory model: byte content is a fixed function of its address.
   assign dma_data = o_Dma_Src_Address[7:0] ^ o_Dma_Src_Address[15:8] ^ 8'h5A;

   wire [33:0] dec_act = {o_Miss, o_Oam_Enable, o_Oam_Address, o_Unusable, o_Io_Enable,
                          o_Io_Address, o_High_Ram_Enable, o_High_Ram_Address,
                          o_Ie_Enable, o_Dma_Reg_Enable, o_Dma_Active};

   function automatic logic [33:0] exp_dec(input logic miss, input logic oam, input logic unus,
                                           input logic [7:0] io, input logic hram, input logic ie,
                                           input logic dreg, input logic act, input logic [15:0] a);
      return {miss, oam, a[7:0], unus, io, a[3:0], hram, a[6:0], ie, dreg, act};
   endfunction

   // Monitor: compares decode snapshots on request and every committed OAM write.
   always @(negedge clk) begin
      if (rst_n && chk_req) begin
         checks++;
         if (dq.size() == 0) begin
            errors++;
            $display("FAIL decode_queue_empty got %h", dec_act);
         end else begin
            mon_e = dq.pop_front();
            mon_n = dname.pop_front();
            if (dec_act !== mon_e) begin
               errors++;
               $display("FAIL decode_%s got %h expected %h", mon_n, dec_act, mon_e);
            end
         end
      end
      if (rst_n && en && o_Dma_Oam_Write) begin
         checks++;
         if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_oam_write got %h/%h/%h expected none",
                     o_Dma_Src_Address, o_Dma_Oam_Address, o_Dma_Oam_Data);
         end else begin
            mon_w = wq.pop_front();
            if ({o_Dma_Src_Address, o_Dma_Oam_Address, o_Dma_Oam_Data} !== mon_w) begin
               errors++;
               $display("FAIL oam_write got %h expected %h",
                        {o_Dma_Src_Address, o_Dma_Oam_Address, o_Dma_Oam_Data}, mon_w);
            end
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
      @(posedge clk);
      #1;
      chk_req = 1'b0;
   endtask

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", n, act, exp);
      end
   endtask

   task automatic dec(input string n, input logic [15:0] a, input logic ao, input logic ac,
                      input logic [33:0] e);
      addr     = a;
      addr_out = ao;
      acc      = ac;
      wr       = 1'b0;
      en       = 1'b1;
      dq.push_back(e);
      dname.push_back(n);
      chk_req  = 1'b1;
      cyc();
   endtask

   task automatic dma_write(input logic [7:0] v);
      addr     = 16'hFF46;
      addr_out = 1'b1;
      acc      = 1'b1;
      wr       = 1'b1;
      wdata    = v;
      en       = 1'b1;
      cyc();
      acc      = 1'b0;
      wr       = 1'b0;
   endtask

   task automatic run(input int n, input logic e);
      acc = 1'b0;
      wr  = 1'b0;
      en  = e;
      repeat (n) cyc();
      en  = 1'b1;
   endtask

   task automatic push_xfer(input logic [7:0] page);
      for (int i = 0; i < 160; i++) begin
         wq.push_back({page, 8'(i), 8'(i), page ^ 8'(i) ^ 8'h5A});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      #23;
      chk("reset_dma", 64'({o_Dma_Active, o_Dma_Read, o_Dma_Oam_Write, o_Dma_Reg}), 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Decode vectors, DMA idle
      dec("reset_held", 16'h1234, 1'b0, 1'b1, exp_dec(1, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000));
      dec("hram_ff85",  16'hFF85, 1'b1, 1'b1, exp_dec(0, 0, 0, 8'h00, 1, 0, 0, 0, 16'hFF85));
      dec("ie_ffff",    16'hFFFF, 1'b1, 1'b1, exp_dec(0, 0, 0, 8'h00, 0, 1, 0, 0, 16'hFFFF));
      dec("oam_fe50",   16'hFE50, 1'b1, 1'b1, exp_dec(0, 1, 0, 8'h00, 0, 0, 0, 0, 16'hFE50));
      dec("oam_fe9f",   16'hFE9F, 1'b1, 1'b1, exp_dec(0, 1, 0, 8'h00, 0, 0, 0, 0, 16'hFE9F));
      dec("unus_fea0",  16'hFEA0, 1'b1, 1'b1, exp_dec(0, 0, 1, 8'h00, 0, 0, 0, 0, 16'hFEA0));
      dec("miss_c000",  16'hC000, 1'b1, 1'b1, exp_dec(1, 0, 0, 8'h00, 0, 0, 0, 0, 16'hC000));
      dec("miss_fdff",  16'hFDFF, 1'b1, 1'b1, exp_dec(1, 0, 0, 8'h00, 0, 0, 0, 0, 16'hFDFF));
      dec("dreg_ff46",  16'hFF46, 1'b1, 1'b1, exp_dec(0, 0, 0, 8'h00, 0, 0, 1, 0, 16'hFF46));
      dec("io4_ff47",   16'hFF47, 1'b1, 1'b1, exp_dec(0, 0, 0, 8'h10, 0, 0, 0, 0, 16'hFF47));
      dec("io7_ff7f",   16'hFF7F, 1'b1, 1'b1, exp_dec(0, 0, 0, 8'h80, 0, 0, 0, 0, 16'hFF7F));
      dec("hram_fffe",  16'hFFFE, 1'b1, 1'b1, exp_dec(0, 0, 0, 8'h00, 1, 0, 0, 0, 16'hFFFE));
      dec("noacc_ff85", 16'hFF85, 1'b1, 1'b0, exp_dec(0, 0, 0, 8'h00, 0, 0, 0, 0, 16'hFF85));
      dec("io1_ff12",   16'hFF12, 1'b1, 1'b1, exp_dec(0, 0, 0, 8'h02, 0, 0, 0, 0, 16'hFF12));
      dec("hold_ff12",  16'hFFFF, 1'b0, 1'b1, exp_dec(0, 0, 0, 8'h02, 0, 0, 0, 0, 16'hFF12));

      // Full transfer from page C1, with an i_Enable gap mid-stream
      push_xfer(8'hC1);
      dma_write(8'hC1);
      chk("delay_state", 64'({o_Dma_Active, o_Dma_Read, o_Dma_Reg}), 64'({1'b1, 1'b0, 8'hC1}));
      run(61, 1'b1);
      chk("index_before_gap", 64'(o_Dma_Oam_Address), 64'h3C);
      run(3, 1'b0);
      chk("index_hold_gap", 64'({o_Dma_Active, o_Dma_Oam_Address}), 64'({1'b1, 8'h3C}));
      run(99, 1'b1);
      chk("before_last", 64'({o_Dma_Active, o_Dma_Oam_Address}), 64'({1'b1, 8'h9F}));
      run(1, 1'b1);
      chk("done_idle", 64'({o_Dma_Active, o_Dma_Read, o_Dma_Reg}), 64'({1'b0, 1'b0, 8'hC1}));
      chk("done_remaining", 64'(wq.size()), 64'd0);

      // E2 maps to source page C2; blocking seen during the copy; restart at index 50
      push_xfer(8'hC2);
      dma_write(8'hE2);
      chk("src_e2", 64'(o_Dma_Src_Address), 64'hC200);
      run(1, 1'b1);
      dec("blk_fe10",  16'hFE10, 1'b1, 1'b1, exp_dec(0, 0, 1, 8'h00, 0, 0, 0, 1, 16'hFE10));
      dec("dma_ff90",  16'hFF90, 1'b1, 1'b1, exp_dec(0, 0, 0, 8'h00, 1, 0, 0, 1, 16'hFF90));
      dec("dma_ff46",  16'hFF46, 1'b1, 1'b1, exp_dec(0, 0, 0, 8'h00, 0, 0, 1, 1, 16'hFF46));
      run(47, 1'b1);
      dma_write(8'h80);
      chk("restart_left", 64'(wq.size()), 64'd109);
      wq.delete();
      push_xfer(8'h80);
      chk("restart_state", 64'({o_Dma_Active, o_Dma_Read, o_Dma_Reg, o_Dma_Src_Address}),
          64'({1'b1, 1'b0, 8'h80, 16'h8000}));
      run(21, 1'b1);
      chk("index_20", 64'(o_Dma_Oam_Address), 64'h14);

      // Asynchronous reset mid-transfer
      rst_n = 1'b0;
      #1;
      chk("reset_mid", 64'({o_Dma_Active, o_Dma_Read, o_Dma_Oam_Write, o_Dma_Src_Address,
                            o_Dma_Oam_Address, o_Dma_Oam_Data, o_Dma_Reg}), 64'h0);
      wq.delete();
      run(2, 1'b1);
      rst_n = 1'b1;
      run(10, 1'b1);
      chk("idle_after_reset", 64'({o_Dma_Active, o_Dma_Read, o_Dma_Reg}), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
